// File: rtl/pooling_layer_controller_pkg.sv
// ---------------------------------------------------------------------------
// pooling_layer_controller_pkg
// Shared constants and types for the pooling layer controller slice.
//   KERNEL_SIZE : pooling window edge, also the samples shifted out per load
//   INPUT_SIZE  : input feature-map edge (a multiple of KERNEL_SIZE)
//   NUM_BLOCKS  : windows per row and number of output rows
//   IDX_W       : width of the block / output-row index ports
//   pool_state_e: controller FSM states
//   idxWidth()  : index width for a counter that runs 0..n-1
// DATA_WIDTH is a macro so that datapath files outside this slice can size
// their buses without importing the package.
// ---------------------------------------------------------------------------
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

package pooling_layer_controller_pkg;

  localparam int KERNEL_SIZE = 2;
  localparam int INPUT_SIZE  = 6;
  localparam int NUM_BLOCKS  = INPUT_SIZE / KERNEL_SIZE;
  localparam int IDX_W       = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } pool_state_e;

  // A one-value counter still needs a one-bit port, so clamp to 1.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pooling_window_counter.sv
// ---------------------------------------------------------------------------
// pooling_window_counter
// Nested window position counter: kernel row inside a window, window column
// block inside a row, and output row. Each level wraps to zero and carries
// into the next one.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   clear_i     : force all three counters to zero
//   advance_i   : step to the next kernel row (with carry)
//   krow_o      : kernel row, 0..KERNEL_SIZE-1
//   block_o     : window column block, 0..NUM_BLOCKS-1
//   row_o       : output row, 0..NUM_BLOCKS-1
//   terminal_o  : all three counters sit at their maximum
// ---------------------------------------------------------------------------
module pooling_window_counter
  import pooling_layer_controller_pkg::*;
#(
  parameter int KERNEL_SIZE = pooling_layer_controller_pkg::KERNEL_SIZE,
  parameter int NUM_BLOCKS  = pooling_layer_controller_pkg::NUM_BLOCKS,
  parameter int KROW_W      = pooling_layer_controller_pkg::idxWidth(KERNEL_SIZE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              advance_i,
  output logic [KROW_W-1:0] krow_o,
  output logic [IDX_W-1:0]  block_o,
  output logic [IDX_W-1:0]  row_o,
  output logic              terminal_o
);

  logic [KROW_W-1:0] krow_q, krow_d;
  logic [IDX_W-1:0]  block_q, block_d;
  logic [IDX_W-1:0]  row_q, row_d;
  logic              krowLast, blockLast, rowLast;

  // Each level is "at max" independently; the carry chain below only lets a
  // level move when every level beneath it is wrapping.
  always_comb begin
    krowLast  = (krow_q  == KROW_W'(KERNEL_SIZE - 1));
    blockLast = (block_q == IDX_W'(NUM_BLOCKS - 1));
    rowLast   = (row_q   == IDX_W'(NUM_BLOCKS - 1));
  end

  // Next-state for the nested counter. Clear has priority so a new map always
  // starts from the origin even if a previous map was cut short.
  always_comb begin
    krow_d  = krow_q;
    block_d = block_q;
    row_d   = row_q;
    if (clear_i) begin
      krow_d  = '0;
      block_d = '0;
      row_d   = '0;
    end else if (advance_i) begin
      if (krowLast) begin
        krow_d = '0;
        if (blockLast) begin
          block_d = '0;
          row_d   = rowLast ? '0 : row_q + IDX_W'(1);
        end else begin
          block_d = block_q + IDX_W'(1);
        end
      end else begin
        krow_d = krow_q + KROW_W'(1);
      end
    end
  end

  // Counter registers, cleared straight away by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      krow_q  <= '0;
      block_q <= '0;
      row_q   <= '0;
    end else begin
      krow_q  <= krow_d;
      block_q <= block_d;
      row_q   <= row_d;
    end
  end

  assign krow_o     = krow_q;
  assign block_o    = block_q;
  assign row_o      = row_q;
  assign terminal_o = krowLast & blockLast & rowLast;

endmodule

// File: rtl/pooling_layer_controller.sv
// ---------------------------------------------------------------------------
// pooling_layer_controller
// Sequences one feature map through a shift buffer: load a KERNEL_SIZE-word
// row segment, shift it out over KERNEL_SIZE cycles, step the window position,
// repeat until every window of every output row has been visited.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   start           : single-cycle request to process one map (IDLE only)
//   in_valid        : upstream row segment is present
//   in_ready        : controller accepts a segment this cycle (LOAD)
//   kernel_calc_fin : buffer load strobe, in_valid & in_ready
//   block_idx       : current window column block
//   krow_idx        : kernel row within the window
//   out_row         : current output row
//   sample_valid    : buffer output holds a valid element (SHIFT)
//   sample_first    : first element of the current window
//   sample_last     : last element of the current window
//   busy            : map in progress (LOAD, SHIFT, DONE)
//   done            : one-cycle completion pulse
// ---------------------------------------------------------------------------
module pooling_layer_controller
  import pooling_layer_controller_pkg::*;
#(
  parameter int   KERNEL_SIZE = pooling_layer_controller_pkg::KERNEL_SIZE,
  parameter int   INPUT_SIZE  = pooling_layer_controller_pkg::INPUT_SIZE,
  localparam int  NUM_BLOCKS  = INPUT_SIZE / KERNEL_SIZE,
  localparam int  KROW_W      = pooling_layer_controller_pkg::idxWidth(KERNEL_SIZE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              kernel_calc_fin,
  output logic [IDX_W-1:0]  block_idx,
  output logic [KROW_W-1:0] krow_idx,
  output logic [IDX_W-1:0]  out_row,
  output logic              sample_valid,
  output logic              sample_first,
  output logic              sample_last,
  output logic              busy,
  output logic              done
);

  pool_state_e       state_q;
  logic [KROW_W-1:0] shiftCnt_q;
  logic              inReady_q;
  logic              sampleValid_q;
  logic              busy_q;
  logic              done_q;

  logic              shiftLast;
  logic              mapLast;
  logic              counterClear;
  logic              counterAdvance;

  // The window counters move once per completed shift burst; they are also
  // zeroed when a map is accepted so a map cut short by reset leaves nothing
  // behind.
  always_comb begin
    shiftLast      = (state_q == ST_SHIFT) && (shiftCnt_q == KROW_W'(KERNEL_SIZE - 1));
    counterClear   = (state_q == ST_IDLE) && start;
    counterAdvance = shiftLast;
  end

  pooling_window_counter #(
    .KERNEL_SIZE (KERNEL_SIZE),
    .NUM_BLOCKS  (NUM_BLOCKS),
    .KROW_W      (KROW_W)
  ) u_window_counter (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (counterClear),
    .advance_i  (counterAdvance),
    .krow_o     (krow_idx),
    .block_o    (block_idx),
    .row_o      (out_row),
    .terminal_o (mapLast)
  );

  // Controller FSM. The status flags are registered alongside the state so
  // they change exactly on the transition into the state they describe.
  // mapLast is sampled before the counters wrap, so the final burst is the
  // one that sees every counter at its maximum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      shiftCnt_q    <= '0;
      inReady_q     <= 1'b0;
      sampleValid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q   <= ST_LOAD;
            inReady_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (in_valid) begin
            state_q       <= ST_SHIFT;
            shiftCnt_q    <= '0;
            inReady_q     <= 1'b0;
            sampleValid_q <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (shiftLast) begin
            shiftCnt_q    <= '0;
            sampleValid_q <= 1'b0;
            if (mapLast) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q   <= ST_LOAD;
              inReady_q <= 1'b1;
            end
          end else begin
            shiftCnt_q <= shiftCnt_q + KROW_W'(1);
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q       <= ST_IDLE;
          inReady_q     <= 1'b0;
          sampleValid_q <= 1'b0;
          busy_q        <= 1'b0;
          done_q        <= 1'b0;
        end
      endcase
    end
  end

  // in_ready is only high in LOAD and sample_valid only in SHIFT, so the load
  // strobe and a valid sample can never coincide.
  assign in_ready        = inReady_q;
  assign kernel_calc_fin = in_valid & inReady_q;
  assign sample_valid    = sampleValid_q;
  assign sample_first    = sampleValid_q && (krow_idx == '0) && (shiftCnt_q == '0);
  assign sample_last     = sampleValid_q && (krow_idx == KROW_W'(KERNEL_SIZE - 1))
                           && (shiftCnt_q == KROW_W'(KERNEL_SIZE - 1));
  assign busy            = busy_q;
  assign done            = done_q;

endmodule

// File: tb/tb_pooling_layer_controller.sv
// Directed bench for pooling_layer_controller with default geometry
// (KERNEL_SIZE=2, INPUT_SIZE=6, so 3x3 windows and 18 loads per map).
module tb_pooling_layer_controller;

  localparam int KS     = 2;
  localparam int NB     = 3;
  localparam int KROW_W = 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              kernel_calc_fin;
  logic [2:0]        block_idx;
  logic [KROW_W-1:0] krow_idx;
  logic [2:0]        out_row;
  logic              sample_valid;
  logic              sample_first;
  logic              sample_last;
  logic              busy;
  logic              done;

  always #5 clk = ~clk;

  pooling_layer_controller #(
    .KERNEL_SIZE (KS),
    .INPUT_SIZE  (6)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .kernel_calc_fin (kernel_calc_fin),
    .block_idx       (block_idx),
    .krow_idx        (krow_idx),
    .out_row         (out_row),
    .sample_valid    (sample_valid),
    .sample_first    (sample_first),
    .sample_last     (sample_last),
    .busy            (busy),
    .done            (done)
  );

  // One record per full-map scenario: stimulus knobs, then expected totals.
  typedef struct {
    string name;
    int    stallFrom;
    int    stallTo;
    int    restartAt;
    int    expDone;
    int    expLoads;
    int    expSamples;
    int    expFirsts;
    int    expLasts;
    int    expBusy;
    int    expFirstSv;
  } vec_t;

  vec_t vecs [3];

  int checks   = 0;
  int failures = 0;

  int nLoads, nSamples, nFirsts, nLasts, nDones, nBusy, nOverlap;
  int doneCycle, firstSvCycle;
  logic [6:0] orderLog [$];

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic v, input logic r);
    start    = s;
    in_valid = v;
    rst      = r;
    #1;
  endtask

  function automatic int outputsWord();
    return int'({in_ready, kernel_calc_fin, block_idx, krow_idx, out_row,
                 sample_valid, sample_first, sample_last, busy, done});
  endfunction

  task automatic clearCounts();
    nLoads = 0; nSamples = 0; nFirsts = 0; nLasts = 0;
    nDones = 0; nBusy = 0; nOverlap = 0;
    doneCycle = -1; firstSvCycle = -1;
    orderLog.delete();
  endtask

  task automatic sampleOutputs(input int cyc);
    if (kernel_calc_fin) begin
      nLoads++;
      orderLog.push_back({out_row, block_idx, krow_idx});
    end
    if (sample_valid) begin
      nSamples++;
      if (firstSvCycle < 0) firstSvCycle = cyc;
    end
    if (sample_first) nFirsts++;
    if (sample_last) nLasts++;
    if (busy) nBusy++;
    if (kernel_calc_fin && sample_valid) nOverlap++;
    if (done) begin
      nDones++;
      if (doneCycle < 0) doneCycle = cyc;
    end
  endtask

  // Expected load order is row-major over (out_row, block_idx, krow_idx).
  task automatic checkOrder(input string name);
    int idx = 0;
    int bad = 0;
    for (int r = 0; r < NB; r++)
      for (int b = 0; b < NB; b++)
        for (int k = 0; k < KS; k++) begin
          if (idx >= orderLog.size() || orderLog[idx] != {3'(r), 3'(b), 1'(k)}) bad++;
          idx++;
        end
    checkOutput({name, " load order errors"}, bad, 0);
  endtask

  // Start a map in cycle 0 and run a fixed budget of cycles past the expected
  // done, so the run always ends even if done never comes.
  task automatic runMap(input vec_t v);
    logic stall;
    clearCounts();
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b0);
    sampleOutputs(0);
    for (int n = 1; n <= v.expDone + 4; n++) begin
      stall = (n >= v.stallFrom) && (n <= v.stallTo);
      nextCycle();
      applyStimulus(n == v.restartAt, !stall, 1'b0);
      sampleOutputs(n);
      if (stall) begin
        checkOutput({v.name, " stall in_ready"}, int'(in_ready), 1);
        checkOutput({v.name, " stall counters"}, int'({out_row, block_idx, krow_idx}), 2);
      end
    end
    checkOutput({v.name, " done cycle"}, doneCycle, v.expDone);
    checkOutput({v.name, " done pulses"}, nDones, 1);
    checkOutput({v.name, " loads"}, nLoads, v.expLoads);
    checkOutput({v.name, " samples"}, nSamples, v.expSamples);
    checkOutput({v.name, " sample_first"}, nFirsts, v.expFirsts);
    checkOutput({v.name, " sample_last"}, nLasts, v.expLasts);
    checkOutput({v.name, " busy cycles"}, nBusy, v.expBusy);
    checkOutput({v.name, " first sample cycle"}, firstSvCycle, v.expFirstSv);
    checkOutput({v.name, " load/sample overlap"}, nOverlap, 0);
    checkOrder(v.name);
  endtask

  initial begin
    int idleBad;

    vecs[0] = '{"full map",       -1, -2, -1, 55, 18, 36, 9, 9, 55, 2};
    vecs[1] = '{"upstream stall",  7, 11, -1, 60, 18, 36, 9, 9, 60, 2};
    vecs[2] = '{"start when busy", -1, -2, 10, 55, 18, 36, 9, 9, 55, 2};

    // Reset then idle: everything low, in_valid without start is ignored.
    applyStimulus(1'b0, 1'b0, 1'b1);
    nextCycle();
    nextCycle();
    checkOutput("reset outputs", outputsWord(), 0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("reset outputs with in_valid", outputsWord(), 0);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b0);
    idleBad = 0;
    for (int n = 0; n < 5; n++) begin
      nextCycle();
      applyStimulus(1'b0, 1'b1, 1'b0);
      if (kernel_calc_fin || in_ready || busy || done) idleBad++;
    end
    checkOutput("idle ignores in_valid", idleBad, 0);

    for (int i = 0; i < 3; i++) runMap(vecs[i]);

    // Mid-map reset on the 7th load (cycle 19 with in_valid held high).
    clearCounts();
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b0);
    sampleOutputs(0);
    for (int n = 1; n <= 19; n++) begin
      nextCycle();
      applyStimulus(1'b0, 1'b1, 1'b0);
      sampleOutputs(n);
    end
    checkOutput("loads before mid-map reset", nLoads, 7);
    checkOutput("7th load strobe", int'(kernel_calc_fin), 1);
    rst = 1'b1;
    #1;
    checkOutput("mid-map reset outputs", outputsWord(), 0);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("held reset outputs", outputsWord(), 0);
    idleBad = 0;
    for (int n = 0; n < 4; n++) begin
      nextCycle();
      applyStimulus(1'b0, 1'b1, 1'b0);
      if (kernel_calc_fin || in_ready || busy || done) idleBad++;
    end
    checkOutput("partial map discarded", idleBad, 0);

    runMap('{"after reset", -1, -2, -1, 55, 18, 36, 9, 9, 55, 2});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pooling_layer_controller.md
POOLING_LAYER_CONTROLLER -- requirements
Module: pooling_layer_controller

Interface
REQ-001 Parameter KERNEL_SIZE, default 2, pooling window edge; also the number of samples shifted per load.
REQ-002 Parameter INPUT_SIZE, default 6, input feature-map edge; INPUT_SIZE SHALL be a multiple of KERNEL_SIZE.
REQ-003 Derived constant NUM_BLOCKS = INPUT_SIZE/KERNEL_SIZE, default 3, used for both blocks per row and output rows.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 start  input  1  single-cycle request to process one feature map.
REQ-008 in_valid  input  1  upstream row segment (KERNEL_SIZE words) is present on the buffer data input.
REQ-009 in_ready  output  1  controller accepts a segment this cycle.
REQ-010 kernel_calc_fin  output  1  buffer load strobe, equal to in_valid & in_ready.
REQ-011 block_idx  output  3  current window column block, 0..NUM_BLOCKS-1.
REQ-012 krow_idx  output  clog2(KERNEL_SIZE)  kernel row within the window.
REQ-013 out_row  output  3  current output row, 0..NUM_BLOCKS-1.
REQ-014 sample_valid  output  1  buffer data_out holds a valid element this cycle.
REQ-015 sample_first / sample_last  output  1 each  first / last element of the current window.
REQ-016 busy  output  1  high from start acceptance until done; done  output  1  one-cycle completion pulse.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, SHIFT and DONE.
REQ-018 IDLE: busy=0; on start=1, go to LOAD with all counters at 0.
REQ-019 LOAD: in_ready=1; on in_valid=1, kernel_calc_fin=1 in the same cycle, clear shift_cnt, go to SHIFT; otherwise wait indefinitely.
REQ-020 SHIFT: lasts exactly KERNEL_SIZE cycles; sample_valid=1 in each; in_ready=0; shift_cnt increments 0..KERNEL_SIZE-1.
REQ-021 sample_first SHALL be asserted when krow_idx=0 and shift_cnt=0.
REQ-022 sample_last SHALL be asserted when krow_idx=KERNEL_SIZE-1 and shift_cnt=KERNEL_SIZE-1.
REQ-023 At the end of SHIFT, counters SHALL advance in nesting order krow_idx, then block_idx, then out_row, each wrapping to 0.
REQ-024 SHIFT SHALL return to LOAD unless all three counters are at their maximum, in which case it goes to DONE.
REQ-025 DONE: done=1 for one cycle, then IDLE; busy=1 in LOAD, SHIFT and DONE.
REQ-026 Latency: the first sample_valid occurs the cycle after the first load handshake; with in_valid tied high, a map completes in NUM_BLOCKS*NUM_BLOCKS*KERNEL_SIZE*(KERNEL_SIZE+1)+1 cycles after start (55 for defaults).
REQ-027 start asserted while busy=1 SHALL be ignored.
REQ-028 in_valid asserted outside LOAD SHALL be ignored, with no load strobe.
REQ-029 start and done in the same cycle: start SHALL be ignored; a new start is accepted only in IDLE.
REQ-030 The controller SHALL never assert kernel_calc_fin and sample_valid in the same cycle.

Reset
REQ-031 While rst=1, the FSM SHALL be in IDLE and all counters 0, at any time including mid-map.
REQ-032 While rst=1, all outputs SHALL be 0, including in_ready, kernel_calc_fin and done.
REQ-033 After rst deasserts, the controller SHALL wait for a fresh start; a partial map is discarded.

Structure
REQ-034 A shared pooling package SHALL hold KERNEL_SIZE, INPUT_SIZE, NUM_BLOCKS, the DATA_WIDTH macro and the FSM state enum.
REQ-035 One sub-module, pooling_window_counter (krow/block/row nested counter with wrap and terminal flag), SHALL be instantiated; the FSM lives in the top module.

Verification
REQ-036 The bench SHALL cover the following directed scenarios:
- Reset then idle: rst pulse -> all outputs 0; in_valid=1 with no start -> no kernel_calc_fin.
- Full map, in_valid tied 1: start -> 18 kernel_calc_fin, 36 sample_valid, 9 sample_first, 9 sample_last, done exactly 55 cycles after start.
- Upstream stall: in_valid low 5 cycles before the 3rd load -> FSM holds LOAD with in_ready=1, counters frozen, total 60 cycles.
- Counter order: log (out_row, block_idx, krow_idx) at each load -> (0,0,0),(0,0,1),(0,1,0)...(2,2,1).
- Start during busy: second start at cycle 10 -> ignored, single done at 55.
- Mid-map reset: rst at the 7th load -> outputs 0 immediately; a new start runs a full 55-cycle map.
